// File: rtl/frame_buf_sched_pkg.sv
// frame_buf_sched_pkg: shared state encoding, buffer count and address defaults for frame_buf_sched
// Buffer count follows FRAME_BUF_TRIPLE_EN (defined: 3 buffers, undefined: 2 buffers).
package frame_buf_sched_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_VSYNC = 3'd1,
        CAPTURE    = 3'd2,
        COMMIT     = 3'd3,
        DROP       = 3'd4
    } state_t;
`ifdef FRAME_BUF_TRIPLE_EN
    localparam int NUM_BUF = 3;
`else
    localparam int NUM_BUF = 2;
`endif
    localparam int IDX_W = 2;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_FRAME_BYTES = 32'h0002_5800;
    localparam int DEF_PIXELS = 76800;
    function automatic logic [31:0] buf_addr(input logic [31:0] base, input logic [31:0] stride,
                                             input logic [IDX_W-1:0] idx);
        return base + 32'(idx) * stride;
    endfunction
endpackage

// File: rtl/frame_buf_sched_buf_alloc.sv
// frame_buf_sched_buf_alloc: picks the lowest buffer index held by neither the latest frame nor the reader
module frame_buf_sched_buf_alloc
    import frame_buf_sched_pkg::*;
(
    input  logic [IDX_W-1:0] latest_idx,
    input  logic             latest_valid,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_valid,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    // scan downward so the last hit is the lowest free index
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (!(latest_valid && latest_idx == IDX_W'(i)) && !(rd_valid && rd_idx == IDX_W'(i))) begin
                found = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: frame buffer scheduler between a capture writer and a display reader
// FRAME_BUF_TRIPLE_EN selects triple buffering (no drops); default build is double buffered.
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int PIXELS_PER_FRAME = DEF_PIXELS
) (
    input  logic        p_clock,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_done,
    input  logic        pixel_valid,
    input  logic        rd_lock,
    output logic        pix_valid_o,
    output logic        wr_frame_start,
    output logic [31:0] wr_base_addr,
    output logic [31:0] rd_base_addr,
    output logic        rd_valid,
    output logic [15:0] frame_drop_cnt,
    output logic        frame_err,
    output logic [2:0]  state_o
);
    state_t state;
    logic fd_q, rl_q, fd_rise, rl_rise, is_commit, alloc_go, alloc_found, latest_valid, lat_valid_eff, pix_room;
    logic [IDX_W-1:0] wr_idx, rd_idx, latest_idx, lat_idx_eff, alloc_idx;
    logic [16:0] pix_cnt;
    assign fd_rise = frame_done & ~fd_q;
    assign rl_rise = rd_lock & ~rl_q;
    assign is_commit = state == COMMIT && enable;
    // a committing frame counts as latest already, both for allocation and for a same-cycle reader grant
    assign lat_idx_eff = is_commit ? wr_idx : latest_idx;
    assign lat_valid_eff = is_commit | latest_valid;
    assign alloc_go = is_commit || ((state == WAIT_VSYNC || state == DROP) && fd_rise);
    assign pix_room = pix_cnt < 17'(PIXELS_PER_FRAME);
    assign pix_valid_o = state == CAPTURE && pixel_valid && pix_room;
    assign state_o = state;
    frame_buf_sched_buf_alloc buf_alloc (
        .latest_idx  (lat_idx_eff),
        .latest_valid(lat_valid_eff),
        .rd_idx      (rd_idx),
        .rd_valid    (rd_valid),
        .found       (alloc_found),
        .idx         (alloc_idx)
    );
    // scheduler FSM, reader grant and frame bookkeeping
    always_ff @(posedge p_clock) begin
        if (rst) begin
            state <= IDLE;
            fd_q <= 1'b0;
            rl_q <= 1'b0;
            wr_frame_start <= 1'b0;
            wr_base_addr <= BASE_ADDR;
            rd_base_addr <= BASE_ADDR;
            rd_valid <= 1'b0;
            frame_drop_cnt <= '0;
            frame_err <= 1'b0;
            pix_cnt <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            latest_idx <= '0;
            latest_valid <= 1'b0;
        end else begin
            fd_q <= frame_done;
            rl_q <= rd_lock;
            wr_frame_start <= 1'b0;
            pix_cnt <= (state == CAPTURE) ? pix_cnt + 17'(pix_valid_o) : '0;
            if (state == CAPTURE && pixel_valid && !pix_room) frame_err <= 1'b1;
            if (rl_rise) begin
                rd_valid <= lat_valid_eff;
                if (lat_valid_eff) begin
                    rd_idx <= lat_idx_eff;
                    rd_base_addr <= buf_addr(BASE_ADDR, FRAME_BYTES, lat_idx_eff);
                end
            end else if (!rd_lock) begin
                rd_valid <= 1'b0;
            end
            if (!enable) begin
                state <= IDLE;
            end else begin
                if (is_commit) begin
                    latest_idx <= wr_idx;
                    latest_valid <= 1'b1;
                end
                case (state)
                    IDLE: state <= WAIT_VSYNC;
                    CAPTURE: begin
                        if (fd_rise) begin
                            if (pix_cnt == 17'(PIXELS_PER_FRAME)) begin
                                state <= COMMIT;
                            end else begin
                                frame_err <= 1'b1;
                                state <= WAIT_VSYNC;
                            end
                        end
                    end
                    default: begin
                        if (alloc_go) begin
                            if (alloc_found) begin
                                state <= CAPTURE;
                                wr_idx <= alloc_idx;
                                wr_base_addr <= buf_addr(BASE_ADDR, FRAME_BYTES, alloc_idx);
                                wr_frame_start <= 1'b1;
                            end else begin
                                state <= DROP;
                                if (frame_drop_cnt != 16'hFFFF) frame_drop_cnt <= frame_drop_cnt + 16'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/frame_buf_sched.md
FRAME_BUF_SCHED -- requirements
Module: frame_buf_sched

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, DDR byte address of buffer 0.
REQ-002 SHALL have parameter FRAME_BYTES, default 32'h0002_5800, buffer stride (320x240x2 bytes).
REQ-003 SHALL have parameter PIXELS_PER_FRAME, default 76800, number of pixel_valid pulses in a complete downscaled frame.
REQ-004 SHALL have port p_clock  in  1  pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high; clock p_clock.
REQ-006 SHALL have port enable  in  1  level; capture permitted while high.
REQ-007 SHALL have port frame_done  in  1  level, high during vsync; its rising edge marks a frame boundary.
REQ-008 SHALL have port pixel_valid  in  1  one-cycle pulse per downscaled pixel from the capture stage.
REQ-009 SHALL have port rd_lock  in  1  level from the display reader; high while it reads a buffer.
REQ-010 SHALL have port pix_valid_o  out  1  pixel_valid gated to the AXI writer.
REQ-011 SHALL have port wr_frame_start  out  1  one-cycle pulse; writer reloads its address from wr_base_addr.
REQ-012 SHALL have port wr_base_addr  out  32  base address of the buffer being written.
REQ-013 SHALL have port rd_base_addr  out  32  base address of the buffer granted to the reader.
REQ-014 SHALL have port rd_valid  out  1  reader grant valid.
REQ-015 SHALL have port frame_drop_cnt  out  16  count of dropped frames, saturating at 16'hFFFF.
REQ-016 SHALL have port frame_err  out  1  sticky flag for a short or long frame.
REQ-017 SHALL have port state_o  out  3  current FSM state encoding.

Function
REQ-018 SHALL detect frame_done rising edge (fd_rise) from a one-register delay of frame_done; rd_lock rising edge (rl_rise) likewise.
REQ-019 SHALL implement FSM states IDLE, WAIT_VSYNC, CAPTURE, COMMIT and DROP.
REQ-020 IDLE SHALL go to WAIT_VSYNC when enable=1; any state SHALL go to IDLE on the cycle after enable=0, and the frame in progress SHALL be discarded without commit.
REQ-021 On fd_rise, WAIT_VSYNC and DROP SHALL allocate a free buffer: the lowest index that is neither latest_idx (when latest_valid) nor rd_idx (when rd_valid).
REQ-022 If allocation succeeds, the FSM SHALL go to CAPTURE, load wr_idx, update wr_base_addr = BASE_ADDR + wr_idx*FRAME_BYTES, and pulse wr_frame_start in the same cycle as the transition.
REQ-023 If allocation fails, the FSM SHALL go to (or stay in) DROP and frame_drop_cnt SHALL increment.
REQ-024 In CAPTURE only, pix_valid_o SHALL equal pixel_valid with zero latency and pix_cnt (17 bits) SHALL increment; in all other states pix_valid_o SHALL be 0.
REQ-025 Pixels beyond PIXELS_PER_FRAME SHALL be blocked from pix_valid_o and SHALL set frame_err.
REQ-026 On fd_rise in CAPTURE, the FSM SHALL go to COMMIT if pix_cnt==PIXELS_PER_FRAME; otherwise it SHALL set frame_err, discard the frame, and go to WAIT_VSYNC.
REQ-027 COMMIT SHALL last exactly one cycle, set latest_idx=wr_idx and latest_valid=1, clear pix_cnt, then allocate per REQ-021..023.
REQ-028 On rl_rise with latest_valid=1, the block SHALL load rd_idx=latest_idx, update rd_base_addr and set rd_valid=1 the next cycle.
REQ-029 On rl_rise with latest_valid=0, rd_valid SHALL stay 0; rd_valid SHALL clear the cycle after rd_lock falls.
REQ-030 If COMMIT and rl_rise occur in the same cycle, the reader SHALL be granted the newly committed buffer.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE.
REQ-032 On rst, all outputs SHALL be 0 except wr_base_addr=BASE_ADDR and rd_base_addr=BASE_ADDR.
REQ-033 On rst, latest_valid, rd_valid, pix_cnt, the edge registers and frame_err SHALL be cleared; reset mid-frame SHALL abandon the frame with no commit.

Configuration
REQ-034 Macro FRAME_BUF_TRIPLE_EN defined SHALL select 3 buffers (idx 0..2); allocation then never fails and DROP is unreachable.
REQ-035 Macro FRAME_BUF_TRIPLE_EN undefined SHALL select 2 buffers (idx 0..1); allocation fails when the reader holds the only non-latest buffer.

Structure
REQ-036 Shared package frame_buf_sched_pkg SHALL hold the state encoding, NUM_BUF derived from the macro, and the default address and size constants.
REQ-037 SHALL instantiate one sub-module, buf_alloc: combinational free-index picker with outputs found and idx.

Verification
REQ-038 Complete frame: enable=1, fd_rise, 76800 pixel pulses, fd_rise -> wr_frame_start with wr_base_addr=32'h1000_0000, one COMMIT, then second start with wr_base_addr=32'h1002_5800.
REQ-039 Short frame: 100 pixels then fd_rise -> frame_err=1, no commit, latest_valid=0, next frame reuses buffer 0.
REQ-040 Reader grant: after commit of buffer 0, rd_lock rises -> rd_valid=1 and rd_base_addr=32'h1000_0000 next cycle; next frame allocated to buffer 1.
REQ-041 Two-buffer drop (macro off): latest=0, reader holds 1, fd_rise -> DROP, frame_drop_cnt=1, pix_valid_o stays 0; with macro on -> buffer 2 (32'h1004_B000).
REQ-042 Same-cycle COMMIT and rl_rise -> reader gets the committed index.
REQ-043 Reset asserted mid-CAPTURE -> all outputs at reset values next cycle, state_o=IDLE.
